// File: rtl/mips_pkg.sv
// Shared opcode/ALU-op encodings and fetch-stage types for the lab2 MIPS datapath.
package mips_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
  localparam logic [5:0] OPCODE_LW    = 6'b100011;
  localparam logic [5:0] OPCODE_SW    = 6'b101011;
  localparam logic [5:0] OPCODE_ANDI  = 6'b001100;
  localparam logic [5:0] OPCODE_ORI   = 6'b001101;
  localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
  localparam logic [5:0] OPCODE_BNE   = 6'b000101;
  localparam logic [5:0] OPCODE_LUI   = 6'b001111;

  // ALU-op codes shared by ALU control and the sign-extend unit.
  localparam logic [2:0] ALUOP_ADD     = 3'b000;
  localparam logic [2:0] ALUOP_LOGIC   = 3'b001;  // zero-extend immediate
  localparam logic [2:0] ALUOP_RTYPE   = 3'b010;
  localparam logic [2:0] ALUOP_BRANCH  = 3'b011;
  localparam logic [2:0] ALUOP_LUI     = 3'b100;
  localparam logic [2:0] ALUOP_DEFAULT = 3'b111;  // sign-extend default

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode -> 3-bit ALU-op decode, sits on the IF/ID input path.
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [2:0] alu_op
);

  // Opcode lookup; anything unrecognised falls back to the sign-extend default.
  always_comb begin
    alu_op = ALUOP_DEFAULT;
    case (opcode)
      OPCODE_RTYPE:                       alu_op = ALUOP_RTYPE;
      OPCODE_ADDI, OPCODE_LW, OPCODE_SW:  alu_op = ALUOP_ADD;
      OPCODE_ANDI, OPCODE_ORI:            alu_op = ALUOP_LOGIC;
      OPCODE_BEQ, OPCODE_BNE:             alu_op = ALUOP_BRANCH;
      OPCODE_LUI:                         alu_op = ALUOP_LUI;
      default:                            alu_op = ALUOP_DEFAULT;
    endcase
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch over a req/ack imem handshake plus the IF/ID pipeline register.
// A one-entry hold buffer absorbs a fetch that lands while ID is stalled.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [15:0] imm16_o,
  output logic [2:0]  alu_op_o
);

  fetch_state_t state_q, state_d;

  logic [31:0] pc_q;
  logic        discard_q, discard_d;
  logic [31:0] discard_addr_q;   // address of the request whose ack will be swallowed
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [2:0]  alu_op_q;

  // Control strobes for the datapath, produced by the FSM process.
  logic        accept;
  logic        req;
  logic        redirect;
  logic        load_mem;
  logic        load_buf;
  logic        capture;
  logic        advance;
  logic        kill;

  logic [31:0] pc_next;
  logic [5:0]  dec_opcode;
  logic [2:0]  dec_alu_op;

  assign accept  = !stall_i || !valid_q;
  assign pc_next = pc_q + PC_INC;  // wraps modulo 2^32

  // Decoder sees whichever word is about to enter IF/ID.
  assign dec_opcode = load_buf ? buf_instr_q[31:26] : imem_data_i[31:26];

  main_decoder u_dec (
    .opcode (dec_opcode),
    .alu_op (dec_alu_op)
  );

  // FSM state and discard flag register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next-state and datapath strobes; priority branch > flush > stall > normal load.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req       = 1'b0;
    redirect  = 1'b0;
    load_mem  = 1'b0;
    load_buf  = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    kill      = 1'b0;

    if (state_q == S_REQ) req = 1'b1;

    if (branch_taken_i) begin
      redirect = 1'b1;
      kill     = 1'b1;
      state_d  = S_REQ;
      // An un-acked request is never aborted; its data must be swallowed later.
      // An ack landing on the branch edge is simply dropped.
      if (state_q == S_REQ)
        discard_d = !imem_ack_i;
      else
        discard_d = discard_q;
    end else if (flush_i) begin
      // Invalidate IF/ID; a word arriving on this edge is younger and is dropped,
      // but the fetch stream keeps going.
      kill = 1'b1;
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack_i) begin
            if (discard_q) discard_d = 1'b0;
            else           advance   = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (imem_ack_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
            end else if (accept) begin
              load_mem = 1'b1;
              advance  = 1'b1;
            end else begin
              capture  = 1'b1;
              advance  = 1'b1;
              state_d  = S_HOLD;
            end
          end else if (accept) begin
            kill = 1'b1;   // ID consumed the current word, nothing new arrived
          end
        end
        S_HOLD: begin
          if (accept) begin
            load_buf = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // PC, outstanding-request address and hold buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q           <= RESET_PC;
      discard_addr_q <= RESET_PC;
      buf_instr_q    <= 32'h0;
      buf_pc_q       <= 32'h0;
    end else begin
      if (redirect) begin
        pc_q <= branch_target_i;
        if (!discard_q) discard_addr_q <= pc_q;
      end else if (advance) begin
        pc_q <= pc_next;
      end
      if (capture) begin
        buf_instr_q <= imem_data_i;
        buf_pc_q    <= pc_next;
      end
    end
  end

  // IF/ID pipeline register; untouched (frozen) unless loaded or killed.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= 1'b0;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      alu_op_q <= 3'b000;
    end else if (load_mem) begin
      valid_q  <= 1'b1;
      instr_q  <= imem_data_i;
      pc_out_q <= pc_next;
      alu_op_q <= dec_alu_op;
    end else if (load_buf) begin
      valid_q  <= 1'b1;
      instr_q  <= buf_instr_q;
      pc_out_q <= buf_pc_q;
      alu_op_q <= dec_alu_op;
    end else if (kill) begin
      valid_q  <= 1'b0;
    end
  end

  // Address stays on the swallowed request until its ack arrives.
  assign imem_req_o  = req;
  assign imem_addr_o = discard_q ? discard_addr_q : pc_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = pc_out_q;
  assign imm16_o     = instr_q[15:0];
  assign alu_op_o    = alu_op_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: fetch/decode, stall hold buffer, branch discard,
// flush, pc wrap and mid-run reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [15:0] imm;
  logic [2:0]  alu;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [64];
  assign data = mem[addr[7:2]];

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_taken_i  (branch),
    .branch_target_i (target),
    .imem_req_o      (req),
    .imem_addr_o     (addr),
    .imem_ack_i      (ack),
    .imem_data_i     (data),
    .valid_o         (valid),
    .instr_o         (instr),
    .pc_o            (pc),
    .imm16_o         (imm),
    .alu_op_o        (alu)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in REQ with pc=0 and IF/ID empty.
  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; branch = 1'b0; ack = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    tests++;
    if ({req, valid, instr, pc, imm, alu, addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 3'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b v=%b i=%h pc=%h imm=%h op=%b a=%h", req, valid, instr, pc, imm, alu, addr);
    end
    step();
    rst = 1'b1;
    step();
    tests++;
    if ({req, valid, addr} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL first_req: got req=%b v=%b a=%h exp req=1 v=0 a=0", req, valid, addr);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    ack = 1'b1;
    step();
    tests++;
    if ({valid, instr, pc, imm, alu, addr} !== {1'b1, 32'h3C01_1234, 32'h4, 16'h1234, 3'b100, 32'h4}) begin
      fails++;
      $display("FAIL fetch_lui: got v=%b i=%h pc=%h imm=%h op=%b a=%h", valid, instr, pc, imm, alu, addr);
    end
    step();
    tests++;
    if ({valid, instr, pc, imm, alu, addr} !== {1'b1, 32'h3422_FFFF, 32'h8, 16'hFFFF, 3'b001, 32'h8}) begin
      fails++;
      $display("FAIL fetch_ori: got v=%b i=%h pc=%h imm=%h op=%b a=%h", valid, instr, pc, imm, alu, addr);
    end
    step();
    tests++;
    if ({valid, instr, pc, imm, alu} !== {1'b1, 32'h2022_8000, 32'hC, 16'h8000, 3'b000}) begin
      fails++;
      $display("FAIL fetch_addi: got v=%b i=%h pc=%h imm=%h op=%b", valid, instr, pc, imm, alu);
    end
    step();
    tests++;
    if ({instr, alu} !== {32'h0022_1820, 3'b010}) begin
      fails++;
      $display("FAIL fetch_rtype: got i=%h op=%b exp 00221820/010", instr, alu);
    end
    step();
    tests++;
    if ({instr, alu} !== {32'h1022_0003, 3'b011}) begin
      fails++;
      $display("FAIL fetch_beq: got i=%h op=%b exp 10220003/011", instr, alu);
    end
    step();
    tests++;
    if ({instr, alu, pc} !== {32'hFC00_0000, 3'b111, 32'h18}) begin
      fails++;
      $display("FAIL fetch_other: got i=%h op=%b pc=%h exp fc000000/111/18", instr, alu, pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ack = 1'b1;
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++;
      if ({req, valid, instr, pc, addr} !== {1'b0, 1'b1, 32'h3C01_1234, 32'h4, 32'h8}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got req=%b v=%b i=%h pc=%h a=%h", k, req, valid, instr, pc, addr);
      end
    end
    stall = 1'b0;
    step();
    tests++;
    if ({req, valid, instr, pc, alu, addr} !== {1'b1, 1'b1, 32'h3422_FFFF, 32'h8, 3'b001, 32'h8}) begin
      fails++;
      $display("FAIL stall_release: got req=%b v=%b i=%h pc=%h op=%b a=%h", req, valid, instr, pc, alu, addr);
    end
    step();
    tests++;
    if ({valid, instr, pc} !== {1'b1, 32'h2022_8000, 32'hC}) begin
      fails++;
      $display("FAIL stall_resume: got v=%b i=%h pc=%h exp 1/20228000/c", valid, instr, pc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ack = 1'b0;
    step();
    branch = 1'b1; target = 32'h40;
    step();
    branch = 1'b0;
    tests++;
    if ({req, valid, addr} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL branch_pending: got req=%b v=%b a=%h exp 1/0/0", req, valid, addr);
    end
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    tests++;
    if ({req, valid, addr} !== {1'b1, 1'b0, 32'h40}) begin
      fails++;
      $display("FAIL branch_swallow: got req=%b v=%b a=%h exp 1/0/40", req, valid, addr);
    end
    ack = 1'b1;
    step();
    tests++;
    if ({valid, instr, pc, alu} !== {1'b1, 32'h8C43_0010, 32'h44, 3'b000}) begin
      fails++;
      $display("FAIL branch_target: got v=%b i=%h pc=%h op=%b", valid, instr, pc, alu);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ack = 1'b1;
    step();
    stall = 1'b1; flush = 1'b1; ack = 1'b0;
    step();
    tests++;
    if ({valid, req, addr} !== {1'b0, 1'b1, 32'h4}) begin
      fails++;
      $display("FAIL flush_kill: got v=%b req=%b a=%h exp 0/1/4", valid, req, addr);
    end
    stall = 1'b0; flush = 1'b0; ack = 1'b1;
    step();
    tests++;
    if ({valid, instr, pc} !== {1'b1, 32'h3422_FFFF, 32'h8}) begin
      fails++;
      $display("FAIL flush_resume: got v=%b i=%h pc=%h exp 1/3422ffff/8", valid, instr, pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ack = 1'b1; branch = 1'b1; target = 32'hFFFF_FFFC;
    step();
    branch = 1'b0;
    tests++;
    if ({valid, req, addr} !== {1'b0, 1'b1, 32'hFFFF_FFFC}) begin
      fails++;
      $display("FAIL branch_with_ack: got v=%b req=%b a=%h exp 0/1/fffffffc", valid, req, addr);
    end
    step();
    tests++;
    if ({valid, instr, pc, addr} !== {1'b1, 32'h0043_1020, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL pc_wrap: got v=%b i=%h pc=%h a=%h", valid, instr, pc, addr);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ack = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    tests++;
    if ({req, valid, instr, pc, imm, alu, addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 3'h0, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset: got req=%b v=%b i=%h pc=%h imm=%h op=%b a=%h", req, valid, instr, pc, imm, alu, addr);
    end
    step();
    rst = 1'b1;
    step();
    tests++;
    if ({req, valid, addr} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL mid_reset_restart: got req=%b v=%b a=%h exp 1/0/0", req, valid, addr);
    end
    step();
    tests++;
    if ({valid, instr, pc} !== {1'b1, 32'h3C01_1234, 32'h4}) begin
      fails++;
      $display("FAIL mid_reset_fetch: got v=%b i=%h pc=%h", valid, instr, pc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hFC00_0000;
    mem[0]  = 32'h3C01_1234;  // lui
    mem[1]  = 32'h3422_FFFF;  // ori
    mem[2]  = 32'h2022_8000;  // addi
    mem[3]  = 32'h0022_1820;  // R-type add
    mem[4]  = 32'h1022_0003;  // beq
    mem[16] = 32'h8C43_0010;  // lw at 0x40
    mem[63] = 32'h0043_1020;  // R-type at 0xFFFF_FFFC (aliased)

    test_reset();
    test_fetch();
    test_stall();
    test_branch();
    test_flush();
    test_wrap();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
